// File: rtl/pe_row_psum_reducer_pkg.sv
// Shared types and helpers for the per-row partial-sum reducer.
package pe_row_psum_reducer_pkg;

    localparam int unsigned PSUM_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        RedIdle,
        RedRun,
        RedDrain,
        RedDone
    } reducer_state_t;

    // Clamp a signed value to the representable range of a width-bit signed number.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] sum,
                                                     input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/pe_row_psum_reducer_tree.sv
// Pipelined, stallable pairwise adder tree: one register stage per level, valid shift chain.
module psum_adder_tree #(
    parameter int unsigned N     = 4,
    parameter int unsigned LANES = 18,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 22
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid_i,
    input  logic [N*LANES*IN_W-1:0]   in_data_i,
    output logic                      out_valid_o,
    output logic [LANES*OUT_W-1:0]    out_data_o
);

    localparam int unsigned T  = $clog2(N);
    localparam int unsigned P  = 1 << T;
    localparam int unsigned TS = (T > 0) ? T : 1;

    typedef logic [P-1:0][LANES-1:0][OUT_W-1:0] level_t;

    level_t           leaf;
    level_t [T:0]     node;
    level_t [TS-1:0]  stage_q, stage_d;
    logic   [TS-1:0]  vld_q, vld_d;

    // Leaves beyond N are zero so the tree is always a full power of two.
    always_comb begin
        leaf = '0;
        for (int i = 0; i < int'(N); i++) begin
            for (int l = 0; l < int'(LANES); l++) begin
                leaf[i][l] = OUT_W'($signed(in_data_i[(i*LANES+l)*IN_W +: IN_W]));
            end
        end
    end

    always_comb begin
        node    = '0;
        node[0] = leaf;
        for (int s = 0; s < int'(T); s++) begin
            node[s+1] = stage_q[s];
        end
    end

    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        if (en) begin
            vld_d[0] = in_valid_i;
            for (int s = 1; s < int'(TS); s++) begin
                vld_d[s] = vld_q[s-1];
            end
            for (int s = 0; s < int'(T); s++) begin
                for (int i = 0; i < int'(P >> (s + 1)); i++) begin
                    for (int l = 0; l < int'(LANES); l++) begin
                        stage_d[s][i][l] = node[s][2*i][l] + node[s][2*i+1][l];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            vld_q   <= '0;
        end else begin
            stage_q <= stage_d;
            vld_q   <= vld_d;
        end
    end

    assign out_data_o = node[T][0];

    if (T == 0) begin : g_comb_valid
        assign out_valid_o = in_valid_i;
    end else begin : g_reg_valid
        assign out_valid_o = vld_q[T-1];
    end

endmodule

// File: rtl/pe_row_psum_reducer.sv
// Joins NUM_COL psum column streams, reduces them through the adder tree, accumulates
// over several passes and hands saturated words downstream.
module pe_row_psum_reducer
    import pe_row_psum_reducer_pkg::*;
#(
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned LANES      = 18,
    parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned ACC_MAX    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cfg_valid_i,
    output logic                                 cfg_ready_o,
    input  logic [NUM_COL-1:0]                   cfg_mask_i,
    input  logic [$clog2(ACC_MAX+1)-1:0]         cfg_acc_i,
    input  logic [15:0]                          cfg_words_i,
    input  logic [NUM_COL-1:0]                   col_valid_i,
    output logic [NUM_COL-1:0]                   col_ready_o,
    input  logic [NUM_COL*LANES*PSUM_WIDTH-1:0]  col_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [LANES*OUT_WIDTH-1:0]           out_data_o,
    output logic                                 sat_o,
    output logic                                 finish_o
);

    localparam int unsigned SUM_W = PSUM_WIDTH + $clog2(NUM_COL) + $clog2(ACC_MAX);
    localparam int unsigned ACC_W = $clog2(ACC_MAX + 1);
    localparam int unsigned COL_W = LANES * PSUM_WIDTH;

    reducer_state_t state_q, state_d;
    logic [NUM_COL-1:0]            mask_q, mask_d;
    logic [ACC_W-1:0]              acc_n_q, acc_n_d, acc_norm;
    logic [ACC_W-1:0]              jpass_q, jpass_d;
    logic [15:0]                   jwords_q, jwords_d;
    logic [15:0]                   words_q, words_d;
    logic [ACC_W-1:0]              pass_q, pass_d;
    logic [LANES-1:0][SUM_W-1:0]   acc_q, acc_d;
    logic                          acc_vld_q, acc_vld_d;
    logic                          acc_last_q, acc_last_d;
    logic                          out_vld_q, out_vld_d;
    logic [LANES*OUT_WIDTH-1:0]    out_data_q, out_data_d;
    logic                          sat_q, sat_d;

    logic                          adv, join_fire, cfg_fire, out_fire;
    logic [NUM_COL*COL_W/LANES*LANES-1:0] tree_in;
    logic                          tree_vld;
    logic [LANES*SUM_W-1:0]        tree_data;
    logic [LANES*OUT_WIDTH-1:0]    clamp_data;
    logic                          clamp_hit;
    logic signed [63:0]            wide, clamped;

    // One global enable: every pipeline register moves only when the output can drain.
    assign adv       = !out_vld_q || out_ready_i;
    assign join_fire = (state_q == RedRun) && adv && (&(col_valid_i | ~mask_q));
    assign cfg_fire  = (state_q == RedIdle) && cfg_valid_i;
    assign out_fire  = out_vld_q && out_ready_i;

    assign col_ready_o = join_fire ? mask_q : '0;
    assign cfg_ready_o = (state_q == RedIdle);
    assign finish_o    = (state_q == RedDone);
    assign out_valid_o = out_vld_q;
    assign out_data_o  = out_data_q;
    assign sat_o       = sat_q;

    always_comb begin
        tree_in = col_data_i;
        for (int c = 0; c < int'(NUM_COL); c++) begin
            if (!mask_q[c]) begin
                tree_in[c*COL_W +: COL_W] = '0;
            end
        end
    end

    psum_adder_tree #(
        .N     (NUM_COL),
        .LANES (LANES),
        .IN_W  (PSUM_WIDTH),
        .OUT_W (SUM_W)
    ) u_tree (
        .clk         (clk),
        .rst         (rst),
        .en          (adv),
        .in_valid_i  (join_fire),
        .in_data_i   (tree_in),
        .out_valid_o (tree_vld),
        .out_data_o  (tree_data)
    );

    always_comb begin
        if (cfg_acc_i == '0) begin
            acc_norm = ACC_W'(1);
        end else if (cfg_acc_i > ACC_W'(ACC_MAX)) begin
            acc_norm = ACC_W'(ACC_MAX);
        end else begin
            acc_norm = cfg_acc_i;
        end
    end

    // Control: job configuration, join-side pass/word counting and the FSM.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        acc_n_d  = acc_n_q;
        jpass_d  = jpass_q;
        jwords_d = jwords_q;
        words_d  = words_q;
        unique case (state_q)
            RedIdle: begin
                if (cfg_valid_i) begin
                    mask_d   = cfg_mask_i;
                    acc_n_d  = acc_norm;
                    jpass_d  = '0;
                    jwords_d = cfg_words_i;
                    words_d  = cfg_words_i;
                    state_d  = (cfg_words_i == 16'd0) ? RedDone : RedRun;
                end
            end
            RedRun: begin
                if (join_fire) begin
                    if (jpass_q == acc_n_q - ACC_W'(1)) begin
                        jpass_d  = '0;
                        jwords_d = jwords_q - 16'd1;
                        if (jwords_q == 16'd1) begin
                            state_d = RedDrain;
                        end
                    end else begin
                        jpass_d = jpass_q + ACC_W'(1);
                    end
                end
            end
            RedDrain: begin
                if (out_fire && words_q == 16'd1) begin
                    state_d = RedDone;
                end
            end
            RedDone: state_d = RedIdle;
            default: state_d = RedIdle;
        endcase
        if (out_fire && words_q != 16'd0) begin
            words_d = words_q - 16'd1;
        end
    end

    always_comb begin
        clamp_data = '0;
        clamp_hit  = 1'b0;
        wide       = '0;
        clamped    = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            wide    = 64'($signed(acc_q[l]));
            clamped = sat_clamp(wide, OUT_WIDTH);
            clamp_data[l*OUT_WIDTH +: OUT_WIDTH] = clamped[OUT_WIDTH-1:0];
            if (clamped != wide) begin
                clamp_hit = 1'b1;
            end
        end
    end

    // Datapath: accumulator stage followed by the saturating output register.
    always_comb begin
        acc_d      = acc_q;
        acc_vld_d  = acc_vld_q;
        acc_last_d = acc_last_q;
        pass_d     = pass_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;
        if (adv) begin
            acc_vld_d = tree_vld;
            if (tree_vld) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    acc_d[l] = (pass_q == '0) ? tree_data[l*SUM_W +: SUM_W]
                                              : acc_q[l] + tree_data[l*SUM_W +: SUM_W];
                end
                acc_last_d = (pass_q == acc_n_q - ACC_W'(1));
                pass_d     = acc_last_d ? '0 : pass_q + ACC_W'(1);
            end
            out_vld_d = acc_vld_q && acc_last_q;
            if (out_vld_d) begin
                out_data_d = clamp_data;
                sat_d      = sat_q | clamp_hit;
            end
        end
        if (cfg_fire) begin
            sat_d  = 1'b0;
            pass_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RedIdle;
            mask_q     <= '0;
            acc_n_q    <= ACC_W'(1);
            jpass_q    <= '0;
            jwords_q   <= '0;
            words_q    <= '0;
            pass_q     <= '0;
            acc_q      <= '0;
            acc_vld_q  <= 1'b0;
            acc_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            acc_n_q    <= acc_n_d;
            jpass_q    <= jpass_d;
            jwords_q   <= jwords_d;
            words_q    <= words_d;
            pass_q     <= pass_d;
            acc_q      <= acc_d;
            acc_vld_q  <= acc_vld_d;
            acc_last_q <= acc_last_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
        end
    end

endmodule
